// File: rtl/svst_pkg.sv
// Shared types and constants for the save-state slot store: FSM encoding,
// image geometry and the rotate-xor checksum step.
package svst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVING  = 2'd1,
        LOADING = 2'd2
    } svst_state_t;

    localparam int SAVE_STATE_BITS = 11;
    localparam int LAST_ADDRESS    = 1055;

    function automatic logic [15:0] svst_chk_step(input logic [15:0] chk, input logic [15:0] word);
        return {chk[14:0], chk[15]} ^ word;
    endfunction

endpackage

// File: rtl/svst_slot_ram.sv
// Single-port synchronous RAM holding all slot images back to back; a write
// takes priority over a read and the read register holds when idle.
module svst_slot_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem [2**ADDR_W];
    logic [15:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/svst_slot_store.sv
// Save-state backing store: NUM_SLOTS images with per-slot validity and a
// checksum recorded on save and verified on every full load sweep.
module svst_slot_store
    import svst_pkg::*;
#(
    parameter int ADDR_BITS = SAVE_STATE_BITS,
    parameter int LAST_ADDR = LAST_ADDRESS,
    parameter int NUM_SLOTS = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
    input  logic                         mem_write_en,
    input  logic                         mem_read_en,
    input  logic [ADDR_BITS-1:0]         mem_addr,
    input  logic [15:0]                  mem_write_data,
    output logic [15:0]                  mem_read_data,
    output logic [NUM_SLOTS-1:0]         slot_valid,
    output logic                         busy,
    output logic                         load_done,
    output logic                         checksum_ok,
    output logic                         seq_error
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam logic [ADDR_BITS-1:0] LAST_A = ADDR_BITS'(LAST_ADDR);

    svst_state_t            state_q, state_d;
    logic [SLOT_W-1:0]      curSlot_q, curSlot_d;
    logic [ADDR_BITS-1:0]   expAddr_q, expAddr_d;
    logic [15:0]            chk_q, chk_d;
    logic [15:0]            chkReg_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   slotValid_q, slotValid_d;
    logic                   rdZero_q, rdZero_d;
    logic                   rdPend_q, rdPend_d;
    logic                   lastPend_q, lastPend_d;
    logic                   loadDone_q, loadDone_d;
    logic                   chkOk_q, chkOk_d;
    logic                   seqErr_q, seqErr_d;

    logic                   chkWrEn;
    logic                   ramWe, ramRe;
    logic [SLOT_W-1:0]      ramSlot;
    logic [15:0]            ramRdata;
    logic                   addrInRange;

    assign addrInRange = (mem_addr <= LAST_A);

    always_comb begin
        state_d     = state_q;
        curSlot_d   = curSlot_q;
        expAddr_d   = expAddr_q;
        chk_d       = chk_q;
        slotValid_d = slotValid_q;
        rdZero_d    = rdZero_q;
        rdPend_d    = 1'b0;
        lastPend_d  = lastPend_q;
        loadDone_d  = 1'b0;
        chkOk_d     = chkOk_q;
        seqErr_d    = seqErr_q;
        chkWrEn     = 1'b0;
        ramWe       = 1'b0;
        ramRe       = 1'b0;
        ramSlot     = slot_sel;

        unique case (state_q)
            IDLE: begin
                lastPend_d = 1'b0;
                if (mem_write_en) begin
                    ramWe = addrInRange;
                    if (mem_addr == '0) begin
                        curSlot_d             = slot_sel;
                        slotValid_d[slot_sel] = 1'b0;
                        chk_d                 = svst_chk_step(16'h0000, mem_write_data);
                        expAddr_d             = ADDR_BITS'(1);
                        state_d               = SAVING;
                    end
                end else if (mem_read_en) begin
                    ramRe    = 1'b1;
                    rdZero_d = !addrInRange || !slotValid_q[slot_sel];
                    if (mem_addr == '0) begin
                        curSlot_d = slot_sel;
                        chk_d     = 16'h0000;
                        expAddr_d = ADDR_BITS'(1);
                        rdPend_d  = 1'b1;
                        state_d   = LOADING;
                    end
                end
            end

            SAVING: begin
                ramSlot = curSlot_q;
                if (mem_write_en) begin
                    if (mem_addr == expAddr_q) begin
                        ramWe     = 1'b1;
                        chk_d     = svst_chk_step(chk_q, mem_write_data);
                        expAddr_d = expAddr_q + 1'b1;
                        if (mem_addr == LAST_A) begin
                            chkWrEn                = 1'b1;
                            slotValid_d[curSlot_q] = 1'b1;
                            state_d                = IDLE;
                        end
                    end else begin
                        seqErr_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            LOADING: begin
                ramSlot = curSlot_q;
                // Fold the word that the previous cycle's read put on the output.
                if (rdPend_q) begin
                    chk_d = svst_chk_step(chk_q, mem_read_data);
                end
                if (lastPend_q) begin
                    chkOk_d    = slotValid_q[curSlot_q] && (chk_d == chkReg_q[curSlot_q]);
                    loadDone_d = 1'b1;
                    lastPend_d = 1'b0;
                    state_d    = IDLE;
                end else if (mem_read_en) begin
                    if (mem_addr == expAddr_q) begin
                        ramRe     = 1'b1;
                        rdZero_d  = !slotValid_q[curSlot_q];
                        rdPend_d  = 1'b1;
                        expAddr_d = expAddr_q + 1'b1;
                        if (mem_addr == LAST_A) begin
                            lastPend_d = 1'b1;
                        end
                    end else begin
                        seqErr_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            curSlot_q   <= '0;
            expAddr_q   <= '0;
            chk_q       <= 16'h0000;
            slotValid_q <= '0;
            rdZero_q    <= 1'b1;
            rdPend_q    <= 1'b0;
            lastPend_q  <= 1'b0;
            loadDone_q  <= 1'b0;
            chkOk_q     <= 1'b0;
            seqErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            curSlot_q   <= curSlot_d;
            expAddr_q   <= expAddr_d;
            chk_q       <= chk_d;
            slotValid_q <= slotValid_d;
            rdZero_q    <= rdZero_d;
            rdPend_q    <= rdPend_d;
            lastPend_q  <= lastPend_d;
            loadDone_q  <= loadDone_d;
            chkOk_q     <= chkOk_d;
            seqErr_q    <= seqErr_d;
        end
    end

    // Stored checksums are meaningless until the slot's valid bit is set.
    always_ff @(posedge clock) begin
        if (!reset && chkWrEn) begin
            chkReg_q[curSlot_q] <= chk_d;
        end
    end

    svst_slot_ram #(
        .ADDR_W(SLOT_W + ADDR_BITS)
    ) u_ram (
        .clock   (clock),
        .we_i    (ramWe && !reset),
        .re_i    (ramRe && !reset),
        .addr_i  ({ramSlot, mem_addr}),
        .wdata_i (mem_write_data),
        .rdata_o (ramRdata)
    );

    assign mem_read_data = rdZero_q ? 16'h0000 : ramRdata;
    assign slot_valid    = slotValid_q;
    assign busy          = (state_q != IDLE);
    assign load_done     = loadDone_q;
    assign checksum_ok   = chkOk_q;
    assign seq_error     = seqErr_q;

endmodule

// File: tb/tb_svst_slot_store.sv
// Directed bench for svst_slot_store: full save/load sweeps, sequence errors,
// mid-sweep slot_sel changes, simultaneous strobes and reset mid-load.
module tb_svst_slot_store;

    localparam int LAST = 1055;

    logic        clock;
    logic        reset;
    logic        slot_sel;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [10:0] mem_addr;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;
    logic [1:0]  slot_valid;
    logic        busy;
    logic        load_done;
    logic        checksum_ok;
    logic        seq_error;

    int checks = 0;
    int passes = 0;

    svst_slot_store dut (
        .clock          (clock),
        .reset          (reset),
        .slot_sel       (slot_sel),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .slot_valid     (slot_valid),
        .busy           (busy),
        .load_done      (load_done),
        .checksum_ok    (checksum_ok),
        .seq_error      (seq_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_save(input logic slot, input logic [15:0] key, input int toggleAt,
                            input logic [1:0] expValid, input string tag);
        int busyBad = 0;
        logic clearedBit = 1'b1;
        logic earlyBit = 1'b1;
        slot_sel = slot;
        for (int a = 0; a <= LAST; a++) begin
            if (toggleAt >= 0 && a >= toggleAt) slot_sel = ~slot;
            mem_write_en   = 1'b1;
            mem_addr       = 11'(a);
            mem_write_data = 16'(a) ^ key;
            step();
            if (a < LAST && busy !== 1'b1) busyBad++;
            if (a == 0) clearedBit = slot_valid[slot];
            if (a == LAST - 1) earlyBit = slot_valid[slot];
        end
        mem_write_en = 1'b0;
        checks++;
        if (busyBad !== 0) $display("[TB] FAIL %s busy_during_save: got %0d low cycles, required 0", tag, busyBad);
        else passes++;
        checks++;
        if (clearedBit !== 1'b0) $display("[TB] FAIL %s valid_cleared_at_start: got %b, required 0", tag, clearedBit);
        else passes++;
        checks++;
        if (earlyBit !== 1'b0) $display("[TB] FAIL %s valid_before_last: got %b, required 0", tag, earlyBit);
        else passes++;
        checks++;
        if (slot_valid !== expValid) $display("[TB] FAIL %s slot_valid_after_save: got %b, required %b", tag, slot_valid, expValid);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL %s busy_after_save: got %b, required 0", tag, busy);
        else passes++;
    endtask

    task automatic run_load(input logic slot, input logic [15:0] key, input logic zeroData,
                            input logic expOk, input string tag);
        int dataBad = 0;
        int doneEarly = 0;
        int busyBad = 0;
        logic [15:0] expWord = 16'h0000;
        logic [15:0] firstGot = 16'h0000;
        logic [15:0] firstExp = 16'h0000;
        slot_sel = slot;
        for (int a = 0; a <= LAST; a++) begin
            mem_read_en = 1'b1;
            mem_addr    = 11'(a);
            step();
            expWord = zeroData ? 16'h0000 : (16'(a) ^ key);
            if (mem_read_data !== expWord) begin
                if (dataBad == 0) begin
                    firstGot = mem_read_data;
                    firstExp = expWord;
                end
                dataBad++;
            end
            if (load_done !== 1'b0) doneEarly++;
            if (busy !== 1'b1) busyBad++;
        end
        mem_read_en = 1'b0;
        checks++;
        if (dataBad !== 0) $display("[TB] FAIL %s load_data: %0d bad words, first got %h required %h", tag, dataBad, firstGot, firstExp);
        else passes++;
        checks++;
        if (doneEarly !== 0 || busyBad !== 0) $display("[TB] FAIL %s load_flags_during_sweep: done_early=%0d busy_low=%0d, required 0/0", tag, doneEarly, busyBad);
        else passes++;
        step();
        checks++;
        if (load_done !== 1'b1) $display("[TB] FAIL %s load_done_pulse: got %b, required 1", tag, load_done);
        else passes++;
        checks++;
        if (checksum_ok !== expOk) $display("[TB] FAIL %s checksum_ok: got %b, required %b", tag, checksum_ok, expOk);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL %s busy_after_load: got %b, required 0", tag, busy);
        else passes++;
        step();
        checks++;
        if (load_done !== 1'b0 || checksum_ok !== expOk) $display("[TB] FAIL %s after_pulse: load_done=%b checksum_ok=%b, required 0/%b", tag, load_done, checksum_ok, expOk);
        else passes++;
        checks++;
        if (mem_read_data !== expWord) $display("[TB] FAIL %s read_data_hold: got %h, required %h", tag, mem_read_data, expWord);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if ({slot_valid, busy, load_done, checksum_ok, seq_error} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b, required 000000", {slot_valid, busy, load_done, checksum_ok, seq_error});
        else passes++;
        checks++;
        if (mem_read_data !== 16'h0000) $display("[TB] FAIL reset_read_data: got %h, required 0000", mem_read_data);
        else passes++;
        slot_sel    = 1'b0;
        mem_read_en = 1'b1;
        mem_addr    = 11'd5;
        step();
        mem_read_en = 1'b0;
        checks++;
        if (mem_read_data !== 16'h0000 || busy !== 1'b0 || slot_valid !== 2'b00)
            $display("[TB] FAIL reset_read_invalid: data=%h busy=%b valid=%b, required 0000/0/00", mem_read_data, busy, slot_valid);
        else passes++;
    endtask

    task automatic test_save_load();
        run_save(1'b1, 16'hA5A5, -1, 2'b10, "save1");
        run_load(1'b1, 16'hA5A5, 1'b0, 1'b1, "load1");
    endtask

    task automatic test_seq_error();
        slot_sel       = 1'b0;
        mem_write_en   = 1'b1;
        mem_addr       = 11'd0;
        mem_write_data = 16'h1111;
        step();
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL seq_busy_start: got %b, required 1", busy);
        else passes++;
        mem_addr       = 11'd1;
        mem_write_data = 16'h2222;
        step();
        mem_addr       = 11'd3;
        mem_write_data = 16'h3333;
        step();
        mem_write_en = 1'b0;
        checks++;
        if (seq_error !== 1'b1 || busy !== 1'b0 || slot_valid !== 2'b10)
            $display("[TB] FAIL seq_abort: seq_error=%b busy=%b valid=%b, required 1/0/10", seq_error, busy, slot_valid);
        else passes++;
        run_load(1'b0, 16'h0000, 1'b1, 1'b0, "load_invalid0");
        checks++;
        if (seq_error !== 1'b1) $display("[TB] FAIL seq_sticky: got %b, required 1", seq_error);
        else passes++;
    endtask

    task automatic test_slot_sel_midsave();
        run_save(1'b1, 16'h3C3C, 100, 2'b10, "save_toggle");
        run_load(1'b1, 16'h3C3C, 1'b0, 1'b1, "load_toggle");
    endtask

    task automatic test_simultaneous();
        slot_sel    = 1'b1;
        mem_read_en = 1'b1;
        mem_addr    = 11'd7;
        step();
        checks++;
        if (mem_read_data !== (16'd7 ^ 16'h3C3C)) $display("[TB] FAIL simul_preread: got %h, required %h", mem_read_data, 16'd7 ^ 16'h3C3C);
        else passes++;
        mem_write_en   = 1'b1;
        mem_write_data = 16'hBEEF;
        step();
        mem_write_en = 1'b0;
        checks++;
        if (mem_read_data !== (16'd7 ^ 16'h3C3C) || busy !== 1'b0)
            $display("[TB] FAIL simul_hold: data=%h busy=%b, required %h/0", mem_read_data, busy, 16'd7 ^ 16'h3C3C);
        else passes++;
        step();
        checks++;
        if (mem_read_data !== 16'hBEEF || slot_valid !== 2'b10)
            $display("[TB] FAIL simul_written: data=%h valid=%b, required beef/10", mem_read_data, slot_valid);
        else passes++;
        mem_addr = 11'd1100;
        step();
        mem_read_en = 1'b0;
        checks++;
        if (mem_read_data !== 16'h0000) $display("[TB] FAIL read_out_of_range: got %h, required 0000", mem_read_data);
        else passes++;
    endtask

    task automatic test_reset_mid_load();
        slot_sel = 1'b1;
        for (int a = 0; a <= 10; a++) begin
            mem_read_en = 1'b1;
            mem_addr    = 11'(a);
            step();
        end
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL midload_busy: got %b, required 1", busy);
        else passes++;
        mem_read_en = 1'b0;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || slot_valid !== 2'b00 || seq_error !== 1'b0 || load_done !== 1'b0)
            $display("[TB] FAIL midload_reset: busy=%b valid=%b seq=%b done=%b, required 0/00/0/0", busy, slot_valid, seq_error, load_done);
        else passes++;
    endtask

    initial begin
        reset          = 1'b1;
        slot_sel       = 1'b0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        mem_addr       = 11'd0;
        mem_write_data = 16'h0000;
        test_reset();
        test_save_load();
        test_seq_error();
        test_slot_sel_midsave();
        test_simultaneous();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
